// File: rtl/move_collector.sv
// Scans NUM_MOVES move words after a start pulse, pushes the legal ones (nonzero initial piece) into a FIFO
// drained on a valid/ready stream. Optional victim-value best-capture tracking under MOVE_COLLECTOR_BEST_CAPTURE_EN.
module move_collector #(
    parameter int NUM_MOVES = 12,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    start,
    input  logic [NUM_MOVES*32-1:0] moves_in,
    output logic [31:0]             move_out,
    output logic                    move_valid,
    input  logic                    move_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        move_count,
    output logic                    overflow
`ifdef MOVE_COLLECTOR_BEST_CAPTURE_EN
    ,
    output logic [31:0]             best_move,
    output logic                    best_valid
`endif
);

    localparam int IDX_W = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [31:0]       words [NUM_MOVES];
    logic [31:0]       cur_word;
    logic              cur_legal, scan_step, start_scan, last;

    for (genvar k = 0; k < NUM_MOVES; k++) begin : g_words
        assign words[k] = moves_in[32*k +: 32];
    end

    assign cur_word   = words[index_q];
    assign cur_legal  = (cur_word[13:8] != 6'd0);
    assign scan_step  = (state_q == SCAN) && enable;
    assign start_scan = (state_q == IDLE) && enable && start;
    assign last       = (index_q == IDX_W'(NUM_MOVES - 1));
    assign busy       = (state_q == SCAN);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (start_scan) begin
                    state_d = SCAN;
                    index_d = '0;
                end
            end
            SCAN: begin
                if (enable) begin
                    if (last) begin
                        state_d = IDLE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO: pointers carry an extra MSB so full and empty are distinguishable.
    logic [31:0]      mem [DEPTH];
    logic [PTR_W:0]   wr_q, rd_q, wr_d, rd_d;
    logic             full, pop, push, drop;
    logic [31:0]      head_d;

    assign full = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign pop  = move_valid && move_ready && enable;
    assign push = scan_step && cur_legal && (!full || pop);
    assign drop = scan_step && cur_legal && full && !pop;
    assign wr_d = wr_q + (PTR_W+1)'(push);
    assign rd_d = rd_q + (PTR_W+1)'(pop);

    // Next head: the word being pushed lands at the head only when the FIFO drains to empty this cycle.
    always_comb begin
        head_d = '0;
        if (rd_d != wr_d) begin
            if (push && (rd_d == wr_q)) head_d = cur_word;
            else                        head_d = mem[rd_d[PTR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[PTR_W-1:0]] <= cur_word;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            index_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            move_out   <= '0;
            move_valid <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            move_out   <= head_d;
            move_valid <= (rd_d != wr_d);
            done       <= scan_step && last;
            if (start_scan) begin
                move_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (scan_step && cur_legal && (move_count != '1))
                    move_count <= move_count + CNT_W'(1);
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

`ifdef MOVE_COLLECTOR_BEST_CAPTURE_EN
    function automatic logic [3:0] victim_score(input logic [4:0] piece);
        case (piece)
            5'b00010: victim_score = 4'd1;
            5'b00001: victim_score = 4'd3;
            5'b01000: victim_score = 4'd3;
            5'b10000: victim_score = 4'd5;
            5'b11000: victim_score = 4'd9;
            5'b00100: victim_score = 4'd15;
            default:  victim_score = 4'd0;
        endcase
    endfunction

    logic [3:0] cur_score, best_score;
    assign cur_score = victim_score(cur_word[28:24]);

    // Strictly-greater compare keeps the earliest word on ties; score 0 is never recorded.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            best_move  <= '0;
            best_score <= '0;
            best_valid <= 1'b0;
        end else if (start_scan) begin
            best_move  <= '0;
            best_score <= '0;
            best_valid <= 1'b0;
        end else if (scan_step && cur_legal && (cur_score > best_score)) begin
            best_move  <= cur_word;
            best_score <= cur_score;
            best_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_move_collector.sv
// Directed scoreboard bench for move_collector (NUM_MOVES=12, DEPTH=4).
module tb_move_collector;
    localparam int NM = 12;
    localparam int DP = 4;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            clear = 1'b1;
    logic            enable = 1'b1;
    logic            start = 1'b0;
    logic            move_ready = 1'b1;
    logic [NM*32-1:0] moves_in = '0;
    logic [31:0]     move_out;
    logic            move_valid, busy, done, overflow;
    logic [CW-1:0]   move_count;
`ifdef MOVE_COLLECTOR_BEST_CAPTURE_EN
    logic [31:0]     best_move;
    logic            best_valid;
`endif

    move_collector #(.NUM_MOVES(NM), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk        (clk),
        .clear      (clear),
        .enable     (enable),
        .start      (start),
        .moves_in   (moves_in),
        .move_out   (move_out),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .busy       (busy),
        .done       (done),
        .move_count (move_count),
        .overflow   (overflow)
`ifdef MOVE_COLLECTOR_BEST_CAPTURE_EN
        ,
        .best_move  (best_move),
        .best_valid (best_valid)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input int cap, input int fin, input int ip, input int pos);
        return {2'b0, 6'(cap), 2'b0, 6'(fin), 2'b0, 6'(ip), 2'b0, 6'(pos)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] w);
        moves_in[32*k +: 32] = w;
    endtask

    task automatic load_all_legal();
        for (int k = 0; k < NM; k++) set_word(k, mkw(0, k + 8, k + 1, k));
    endtask

    task automatic expect_words(input int first, input int last_k);
        for (int k = first; k <= last_k; k++) exp_q.push_back(moves_in[32*k +: 32]);
    endtask

    // Pulses start, then counts cycles (start edge = cycle 1) until done is seen.
    task automatic run_scan(input int gap_at, input int exp_done);
        int cyc;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 80) begin
            if (cyc == gap_at)     enable = 1'b0;
            if (cyc == gap_at + 5) enable = 1'b1;
            tick();
            cyc++;
        end
        enable = 1'b1;
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        tick();
        chk("done_one_pulse", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        tick();
        chk("valid_low_after_drain", 32'(move_valid), 32'd0);
    endtask

    initial begin
        int seen;

        // Reset state, observed before any clock edge.
        #1;
        chk("rst_move_out", move_out, 32'd0);
        chk("rst_move_valid", 32'(move_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_move_count", 32'(move_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        tick();
        clear = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!clear && move_valid && move_ready && enable) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL stream_unexpected: got 0x%0h, expected no word", move_out);
                    end else begin
                        chk("stream_word", move_out, exp_q.pop_front());
                    end
                end
            end
        join_none

        seen = 0;
        repeat (20) begin
            tick();
            if (done || move_valid) seen++;
        end
        chk("idle_no_activity", 32'(seen), 32'd0);

        // Single legal word: white queen sq0 captures black queen sq2.
        moves_in = '0;
        set_word(4, {2'b0, 6'b011000, 2'b0, 6'd2, 2'b0, 6'b111000, 2'b0, 6'd0});
        chk("word4_encoding", moves_in[4*32 +: 32], 32'h18023800);
        exp_q.push_back(32'h18023800);
        run_scan(-100, 13);
        chk("single_count", 32'(move_count), 32'd1);
        chk("single_overflow", 32'(overflow), 32'd0);
        drain();

        // Backpressured: only four words fit, the rest are dropped but counted.
        load_all_legal();
        move_ready = 1'b0;
        expect_words(0, 3);
        run_scan(-100, 13);
        chk("full_count", 32'(move_count), 32'd12);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_valid", 32'(move_valid), 32'd1);
        chk("full_head", move_out, mkw(0, 8, 1, 0));
        move_ready = 1'b1;
        drain();

        // Free-flowing: all twelve in index order.
        expect_words(0, NM - 1);
        run_scan(-100, 13);
        chk("flow_count", 32'(move_count), 32'd12);
        chk("flow_overflow", 32'(overflow), 32'd0);
        drain();

        // Enable dropped for five cycles mid-scan.
        expect_words(0, NM - 1);
        run_scan(4, 18);
        chk("gap_count", 32'(move_count), 32'd12);
        drain();

        // Clear at scan cycle 6, then rescan from word 0.
        move_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_clear_busy", 32'(busy), 32'd1);
        chk("pre_clear_valid", 32'(move_valid), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_valid", 32'(move_valid), 32'd0);
        chk("clear_count", 32'(move_count), 32'd0);
        exp_q.delete();
        tick();
        clear = 1'b0;
        move_ready = 1'b1;
        expect_words(0, NM - 1);
        run_scan(-100, 13);
        chk("rescan_count", 32'(move_count), 32'd12);
        drain();

`ifdef MOVE_COLLECTOR_BEST_CAPTURE_EN
        // Rook at word 3, queen at word 7; later rook and tied queen must not replace.
        load_all_legal();
        set_word(3,  mkw(6'b010000, 20, 6'b100001, 3));
        set_word(7,  mkw(6'b011000, 21, 6'b100010, 7));
        set_word(9,  mkw(6'b010000, 22, 6'b100001, 9));
        set_word(10, mkw(6'b011000, 23, 6'b100010, 10));
        expect_words(0, NM - 1);
        run_scan(-100, 13);
        chk("best_move", best_move, mkw(6'b011000, 21, 6'b100010, 7));
        chk("best_valid", 32'(best_valid), 32'd1);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
